mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
- Parametrised memory-mapped peripheral controller that replaces the hard-coded IO decode of the data-memory port with a registered, handshaked slave.
- Serves the CPU load/store unit for the window 0xFFFF_FF00–0xFFFF_FFFF.
- Provides N switch banks, N LED banks and N seven-segment registers, byte-enabled writes, debounced buttons with sticky press capture, a sepc readback and a free-running cycle counter.

Parameters:
- N_SW, 3: number of 8-bit switch banks; 1..16.
- N_LED, 2: number of LED registers; 1..16.
- LED_W, 8: LED register width; 1..32.
- N_SEG, 2: number of 32-bit seven-segment registers; 1..8.
- N_BTN, 5: number of buttons; 1..32. Bit 0 = middle, then up, down, left, right.
- DEB_CYCLES, 20000: cycles a synchronised button input must stay stable before the debounced level changes; ≥2.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request, valid for one cycle.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  32  byte address; only [7:2] is decoded, [31:8] is decoded by the requester.
- wdata  in  32  write data, byte lane aligned.
- be  in  4  byte enables for writes; ignored on reads.
- rdata  out  32  read data, valid while ack = 1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  qualifies ack; high for an unmapped or illegal access.
- switches  in  8*N_SW  raw switch inputs, bank i = bits [8i+7:8i].
- buttons  in  N_BTN  raw asynchronous button inputs.
- sepc  in  32  exception PC for readback.
- led_out  out  LED_W*N_LED  LED registers.
- seg_out  out  32*N_SEG  seven-segment registers.

Behaviour:
- Reset: rst_n low asynchronously clears all LED, seg, debounce, sticky and counter state, and forces rdata = 0, ack = 0, err = 0. The synchroniser flops clear to 0. An in-flight request is dropped and no ack is issued for it.
- Latency: req in cycle T produces ack = 1 for exactly one cycle at T+1, with rdata/err registered. Back-to-back req every cycle is legal, giving one ack per req in order. No ready/backpressure exists.
- Address map, offset = addr[7:0]:
  - 0x00+4i: switch bank i, read-only, zero-extended.
  - 0x40+4i: LED i, read/write, zero-extended on read.
  - 0x80: debounced button levels, read-only.
  - 0x84: sticky press bits. A read returns the bits and clears them. A write-1-to-clear uses wdata masked by be.
  - 0xC0+4i: seg i, read/write.
  - 0xF0: sepc, read-only.
  - 0xF4: cycle counter, read-only. 32-bit, +1 every cycle, wraps 0xFFFF_FFFF→0.
- Illegal accesses: index ≥ bank count, a write to a read-only register, or any other offset. Response is ack = 1, err = 1, rdata = 0, and no state changes.
- Writes: each enabled byte lane updates its byte of the target register. LED lanes beyond LED_W are discarded. be = 0 is a legal no-op write with err = 0. A write's effect is visible on led_out/seg_out at T+1. A read of the same register at T+1 returns the new value.
- Read data is sampled at T. A read at T+1 sees any write made at T.
- Buttons, per bit:
  - A 2-flop synchroniser feeds the debouncer.
  - The counter resets whenever the synchronised value equals the debounced level. Otherwise it increments.
  - When the counter reaches DEB_CYCLES-1, the level toggles and the counter clears.
  - A 0→1 transition of the debounced level sets the sticky bit.
- Sticky simultaneity: if a set event and a clear (read or W1C) fall on the same cycle for the same bit, set wins and the bit stays 1. The read still returns the pre-clear value.
- Switches are sampled through a 2-flop synchroniser, so reads see values 2–3 cycles old.
- Inputs are ignored while rst_n = 0. Requests after reset release are serviced normally on the first rising edge.

Decomposition:
- Package mmio_pkg:
  - offset constants: OFF_SW, OFF_LED, OFF_BTN_LVL, OFF_BTN_STICKY, OFF_SEG, OFF_SEPC, OFF_CYC.
  - MMIO_BASE = 32'hFFFF_FF00.
  - a 2-bit resp_t enum {RESP_OK, RESP_ERR}.
- Sub-module btn_debounce (params DEB_CYCLES): synchroniser, counter and level output for one button, plus a rise pulse. Instantiated N_BTN times via generate.

Test Plan:
- Reset then read 0xF0 with sepc = 0x1C09_0040 → ack at T+1, rdata = 0x1C09_0040, err = 0. Read 0x40 → 0.
- Write 0xC4 with wdata = 0xA5A5_1234, be = 4'b0011, N_SEG = 2, seg1 previously 0xFFFF_FFFF → seg_out[63:32] = 0xFFFF_1234 at T+1. A read of 0xC4 returns the same value.
- Button 2 held high for DEB_CYCLES+4 cycles (DEB_CYCLES = 8) → read 0x80 gives bit2 = 1, read 0x84 gives 0x4, a second read of 0x84 gives 0x0. A 5-cycle glitch → no change.
- Rise of button 0 on the same cycle as a W1C of 0x84 with wdata = 0x1 → bit0 remains 1.
- Write 0x00 (switch bank 0), read 0x4C with N_LED = 2, read 0x7C → each gives ack = 1, err = 1, rdata = 0, with LEDs unchanged.
- Assert rst_n low mid-debounce and during a pending req → no ack follows, all outputs are 0, and the counter at 0xF4 restarts from 0 after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared offsets, response encoding and byte-lane helper for the MMIO slave.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE      = 32'hFFFF_FF00;
    localparam logic [7:0]  OFF_SW         = 8'h00;
    localparam logic [7:0]  OFF_LED        = 8'h40;
    localparam logic [7:0]  OFF_BTN_LVL    = 8'h80;
    localparam logic [7:0]  OFF_BTN_STICKY = 8'h84;
    localparam logic [7:0]  OFF_SEG        = 8'hC0;
    localparam logic [7:0]  OFF_SEPC       = 8'hF0;
    localparam logic [7:0]  OFF_CYC        = 8'hF4;

    typedef enum logic [1:0] {
        RESP_OK  = 2'd0,
        RESP_ERR = 2'd1
    } resp_t;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/mmio_ctrl_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, debounced level and
// a single-cycle pulse coinciding with the level's 0->1 update.
module btn_debounce
    import mmio_pkg::*;
#(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) lvl_d = ~lvl_q;
            else                              cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= btn_i;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign level_o = lvl_q;
    assign rise_o  = lvl_d & ~lvl_q;

endmodule

// File: rtl/mmio_ctrl.sv
// Registered single-cycle MMIO slave: switches, LEDs, buttons, seven-segment,
// sepc readback and cycle counter in the 256-byte window at MMIO_BASE.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int N_SW       = 3,
    parameter int N_LED      = 2,
    parameter int LED_W      = 8,
    parameter int N_SEG      = 2,
    parameter int N_BTN      = 5,
    parameter int DEB_CYCLES = 20000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic                   we,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic [3:0]             be,
    output logic [31:0]            rdata,
    output logic                   ack,
    output logic                   err,
    input  logic [8*N_SW-1:0]      switches,
    input  logic [N_BTN-1:0]       buttons,
    input  logic [31:0]            sepc,
    output logic [LED_W*N_LED-1:0] led_out,
    output logic [32*N_SEG-1:0]    seg_out
);

    logic [N_LED-1:0][LED_W-1:0] led_q, led_d;
    logic [N_SEG-1:0][31:0]      seg_q, seg_d;
    logic [N_SW-1:0][7:0]        sw_s1_q, sw_s2_q;
    logic [N_BTN-1:0]            sticky_q, sticky_d, sticky_clr, btn_lvl, btn_rise;
    logic [31:0]                 cyc_q, rdata_q, rdata_d, wmask;
    logic                        ack_q, legal;
    resp_t                       resp_q, resp_d;
    logic [7:0]                  off;
    int                          idx;
    logic                        unused_addr;

    assign unused_addr = ^{addr[31:8], addr[1:0]};
    assign off         = {addr[7:2], 2'b00};
    assign idx         = int'({28'd0, addr[5:2]});
    assign wmask       = be_mask(be);

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .btn_i  (buttons[b]),
            .level_o(btn_lvl[b]),
            .rise_o (btn_rise[b])
        );
    end

    // State updates are only applied for legal accesses; illegal ones just report err.
    always_comb begin
        led_d      = led_q;
        seg_d      = seg_q;
        sticky_clr = '0;
        rdata_d    = '0;
        legal      = 1'b0;
        if (req) begin
            case (off[7:6])
                2'b00: if (!we && idx < N_SW) begin
                    legal = 1'b1;
                    for (int i = 0; i < N_SW; i++)
                        if (idx == i) rdata_d = 32'(sw_s2_q[i]);
                end
                2'b01: if (idx < N_LED) begin
                    legal = 1'b1;
                    for (int i = 0; i < N_LED; i++) if (idx == i) begin
                        rdata_d = 32'(led_q[i]);
                        if (we) led_d[i] = LED_W'((32'(led_q[i]) & ~wmask) | (wdata & wmask));
                    end
                end
                2'b10: if (off == OFF_BTN_LVL && !we) begin
                    legal   = 1'b1;
                    rdata_d = 32'(btn_lvl);
                end else if (off == OFF_BTN_STICKY) begin
                    legal      = 1'b1;
                    rdata_d    = 32'(sticky_q);
                    sticky_clr = we ? N_BTN'(wdata & wmask) : '1;
                end
                default: if (idx < N_SEG) begin
                    legal = 1'b1;
                    for (int i = 0; i < N_SEG; i++) if (idx == i) begin
                        rdata_d = seg_q[i];
                        if (we) seg_d[i] = (seg_q[i] & ~wmask) | (wdata & wmask);
                    end
                end else if (off == OFF_SEPC && !we) begin
                    legal   = 1'b1;
                    rdata_d = sepc;
                end else if (off == OFF_CYC && !we) begin
                    legal   = 1'b1;
                    rdata_d = cyc_q;
                end
            endcase
        end
        resp_d = (req && !legal) ? RESP_ERR : RESP_OK;
        if (!legal || we) rdata_d = '0;
    end

    // A press landing on the same cycle as a clear keeps its sticky bit.
    assign sticky_d = (sticky_q & ~sticky_clr) | btn_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q    <= '0;
            seg_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            sticky_q <= '0;
            cyc_q    <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            resp_q   <= RESP_OK;
        end else begin
            led_q    <= led_d;
            seg_q    <= seg_d;
            sw_s1_q  <= switches;
            sw_s2_q  <= sw_s1_q;
            sticky_q <= sticky_d;
            cyc_q    <= cyc_q + 32'd1;
            rdata_q  <= rdata_d;
            ack_q    <= req;
            resp_q   <= resp_d;
        end
    end

    assign rdata   = rdata_q;
    assign ack     = ack_q;
    assign err     = ack_q && (resp_q == RESP_ERR);
    assign led_out = led_q;
    assign seg_out = seg_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Bench for mmio_ctrl: directed scenarios plus randomized traffic against a
// behavioural register-map model.
module tb_mmio_ctrl;

    localparam int N_SW = 3, N_LED = 2, LED_W = 12, N_SEG = 2, N_BTN = 5, DEB = 8;
    localparam logic [31:0] LMASK = 32'((64'd1 << LED_W) - 64'd1);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req = 1'b0, we = 1'b0;
    logic [31:0]            addr = '0, wdata = '0, sepc = '0;
    logic [3:0]             be = '0;
    logic [31:0]            rdata;
    logic                   ack, err;
    logic [8*N_SW-1:0]      switches = '0;
    logic [N_BTN-1:0]       buttons = '0;
    logic [LED_W*N_LED-1:0] led_out;
    logic [32*N_SEG-1:0]    seg_out;

    int pass_cnt = 0, tot_cnt = 0;

    mmio_ctrl #(.N_SW(N_SW), .N_LED(N_LED), .LED_W(LED_W), .N_SEG(N_SEG),
                .N_BTN(N_BTN), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .rdata(rdata), .ack(ack), .err(err), .switches(switches),
        .buttons(buttons), .sepc(sepc), .led_out(led_out), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++) if (b[j]) r[8*j +: 8] = d[8*j +: 8];
        return r;
    endfunction

    // One access: drive on a falling edge, capture the response one cycle later.
    task automatic do_acc(input logic w, input logic [7:0] o, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic a,
                          output logic e);
        @(negedge clk);
        req = 1'b1; we = w; addr = {24'hFFFFFF, o}; wdata = d; be = b;
        @(negedge clk);
        rd = rdata; a = ack; e = err;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic a, e;
        req = 1'b1; addr = 32'hFFFF_FFF4;
        repeat (3) @(negedge clk);
        tot_cnt++; if (ack !== 1'b0)  $display("FAIL reset_ack: got %b want 0", ack); else pass_cnt++;
        tot_cnt++; if (err !== 1'b0)  $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
        tot_cnt++; if (rdata !== '0)  $display("FAIL reset_rdata: got %h want 0", rdata); else pass_cnt++;
        tot_cnt++; if (led_out !== '0) $display("FAIL reset_led: got %h want 0", led_out); else pass_cnt++;
        tot_cnt++; if (seg_out !== '0) $display("FAIL reset_seg: got %h want 0", seg_out); else pass_cnt++;
        req = 1'b0; rst_n = 1'b1;
        sepc = 32'h1C09_0040;
        do_acc(1'b0, 8'hF0, '0, 4'h0, rd, a, e);
        tot_cnt++; if (a !== 1'b1 || e !== 1'b0) $display("FAIL sepc_resp: got ack=%b err=%b want 1/0", a, e); else pass_cnt++;
        tot_cnt++; if (rd !== 32'h1C09_0040) $display("FAIL sepc_read: got %h want 1c090040", rd); else pass_cnt++;
        do_acc(1'b0, 8'h40, '0, 4'h0, rd, a, e);
        tot_cnt++; if (a !== 1'b1 || e !== 1'b0 || rd !== '0) $display("FAIL led0_reset_read: got ack=%b err=%b rd=%h want 1/0/0", a, e, rd); else pass_cnt++;
    endtask

    task automatic test_random(input int n);
        logic [31:0] led_m [N_LED];
        logic [31:0] seg_m [N_SEG];
        logic [LED_W*N_LED-1:0] led_exp;
        logic [32*N_SEG-1:0]    seg_exp;
        logic [31:0] sw_m, exp_rd, wd;
        logic        exp_ack, exp_err, rd_chk, ok, wr;
        logic [3:0]  b;
        int          word, off, quiet;
        for (int i = 0; i < N_LED; i++) led_m[i] = '0;
        for (int i = 0; i < N_SEG; i++) seg_m[i] = '0;
        quiet = 0; exp_ack = 0; exp_err = 0; rd_chk = 0; exp_rd = '0; sw_m = '0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            tot_cnt++; if (ack !== exp_ack) $display("FAIL rnd_ack[%0d]: got %b want %b", k, ack, exp_ack); else pass_cnt++;
            if (exp_ack) begin
                tot_cnt++; if (err !== exp_err) $display("FAIL rnd_err[%0d]: got %b want %b", k, err, exp_err); else pass_cnt++;
                if (rd_chk) begin
                    tot_cnt++; if (rdata !== exp_rd) $display("FAIL rnd_rdata[%0d]: got %h want %h", k, rdata, exp_rd); else pass_cnt++;
                end
            end
            for (int i = 0; i < N_LED; i++) led_exp[i*LED_W +: LED_W] = led_m[i][LED_W-1:0];
            for (int i = 0; i < N_SEG; i++) seg_exp[i*32 +: 32] = seg_m[i];
            tot_cnt++; if (led_out !== led_exp) $display("FAIL rnd_led[%0d]: got %h want %h", k, led_out, led_exp); else pass_cnt++;
            tot_cnt++; if (seg_out !== seg_exp) $display("FAIL rnd_seg[%0d]: got %h want %h", k, seg_out, seg_exp); else pass_cnt++;
            req = 1'b0; we = 1'b0; exp_ack = 1'b0;
            if (k == n) break;
            if (k % 20 == 0) begin
                switches = 24'($urandom); sw_m = 32'(switches); quiet = 3;
            end
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 7) != 0) begin
                word = $urandom_range(0, 63);
                if (word == 61) word = 60;
                wr = 1'($urandom); wd = $urandom; b = 4'($urandom); sepc = $urandom;
                off = word * 4; ok = 1'b0; exp_rd = '0;
                if (off < 'h40) begin
                    if (!wr && word < N_SW) begin ok = 1'b1; exp_rd = (sw_m >> (8 * word)) & 32'hFF; end
                end else if (off < 'h80) begin
                    if (word - 16 < N_LED) begin
                        ok = 1'b1;
                        if (wr) led_m[word-16] = merge(led_m[word-16], wd, b) & LMASK;
                        else    exp_rd = led_m[word-16];
                    end
                end else if (off == 'h80) begin
                    ok = !wr;
                end else if (off == 'h84) begin
                    ok = 1'b1;
                end else if (off >= 'hC0 && off < 'hC0 + 4 * N_SEG) begin
                    ok = 1'b1;
                    if (wr) seg_m[(off-'hC0)/4] = merge(seg_m[(off-'hC0)/4], wd, b);
                    else    exp_rd = seg_m[(off-'hC0)/4];
                end else if (off == 'hF0) begin
                    ok = !wr; exp_rd = sepc;
                end
                if (!ok) exp_rd = '0;
                req = 1'b1; we = wr; wdata = wd; be = b;
                addr = {24'($urandom), 6'(word), 2'($urandom)};
                exp_ack = 1'b1; exp_err = !ok; rd_chk = !wr || !ok;
            end
        end
    endtask

    task automatic test_seg_led();
        logic [31:0] rd; logic a, e;
        do_acc(1'b1, 8'hC4, 32'hFFFF_FFFF, 4'hF, rd, a, e);
        do_acc(1'b1, 8'hC4, 32'hA5A5_1234, 4'b0011, rd, a, e);
        tot_cnt++; if (a !== 1'b1 || e !== 1'b0) $display("FAIL seg1_wr_resp: got ack=%b err=%b want 1/0", a, e); else pass_cnt++;
        tot_cnt++; if (seg_out[63:32] !== 32'hFFFF_1234) $display("FAIL seg1_out: got %h want ffff1234", seg_out[63:32]); else pass_cnt++;
        do_acc(1'b0, 8'hC4, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'hFFFF_1234) $display("FAIL seg1_read: got %h want ffff1234", rd); else pass_cnt++;
        do_acc(1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, rd, a, e);
        tot_cnt++; if (led_out[11:0] !== 12'hFFF) $display("FAIL led0_trunc: got %h want fff", led_out[11:0]); else pass_cnt++;
        do_acc(1'b0, 8'h40, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h0000_0FFF) $display("FAIL led0_read: got %h want 00000fff", rd); else pass_cnt++;
        do_acc(1'b1, 8'h44, 32'h0, 4'hF, rd, a, e);
        do_acc(1'b1, 8'h44, 32'h0000_0ABC, 4'b0001, rd, a, e);
        tot_cnt++; if (led_out[23:12] !== 12'h0BC) $display("FAIL led1_lane0: got %h want 0bc", led_out[23:12]); else pass_cnt++;
        do_acc(1'b1, 8'h44, 32'hFFFF_FFFF, 4'b0000, rd, a, e);
        tot_cnt++; if (e !== 1'b0 || led_out[23:12] !== 12'h0BC) $display("FAIL led1_be0: got err=%b led=%h want 0/0bc", e, led_out[23:12]); else pass_cnt++;
        do_acc(1'b1, 8'h44, 32'h0000_FA00, 4'b0010, rd, a, e);
        tot_cnt++; if (led_out[23:12] !== 12'hABC) $display("FAIL led1_lane1: got %h want abc", led_out[23:12]); else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [7:0] offs [7] = '{8'h00, 8'h4C, 8'h7C, 8'h80, 8'hF0, 8'hF4, 8'hE0};
        logic       wrs  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] rd; logic a, e;
        for (int i = 0; i < 7; i++) begin
            do_acc(wrs[i], offs[i], 32'hFFFF_FFFF, 4'hF, rd, a, e);
            tot_cnt++; if (a !== 1'b1 || e !== 1'b1 || rd !== '0) $display("FAIL illegal_%h: got ack=%b err=%b rd=%h want 1/1/0", offs[i], a, e, rd); else pass_cnt++;
            tot_cnt++; if (led_out !== {12'hABC, 12'hFFF}) $display("FAIL illegal_led_%h: got %h want abcfff", offs[i], led_out); else pass_cnt++;
            tot_cnt++; if (seg_out[63:32] !== 32'hFFFF_1234) $display("FAIL illegal_seg_%h: got %h want ffff1234", offs[i], seg_out[63:32]); else pass_cnt++;
        end
    endtask

    task automatic test_buttons();
        logic [31:0] rd; logic a, e;
        @(negedge clk); buttons[2] = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        do_acc(1'b0, 8'h80, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h4) $display("FAIL btn_level: got %h want 4", rd); else pass_cnt++;
        do_acc(1'b0, 8'h84, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h4) $display("FAIL btn_sticky: got %h want 4", rd); else pass_cnt++;
        do_acc(1'b0, 8'h84, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h0) $display("FAIL btn_sticky_clr: got %h want 0", rd); else pass_cnt++;
        @(negedge clk); buttons[2] = 1'b0; buttons[3] = 1'b1;
        repeat (5) @(negedge clk);
        buttons[2] = 1'b1; buttons[3] = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        do_acc(1'b0, 8'h80, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h4) $display("FAIL btn_glitch_level: got %h want 4", rd); else pass_cnt++;
        do_acc(1'b0, 8'h84, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h0) $display("FAIL btn_glitch_sticky: got %h want 0", rd); else pass_cnt++;
    endtask

    // The level rises DEB+2 edges after the raw input changes; the W1C is timed onto that edge.
    task automatic test_sticky_race();
        logic [31:0] rd; logic a, e;
        @(negedge clk); buttons[0] = 1'b1;
        repeat (DEB + 1) @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'hFFFF_FF84; wdata = 32'h1; be = 4'hF;
        @(negedge clk);
        tot_cnt++; if (ack !== 1'b1 || err !== 1'b0) $display("FAIL race_w1c_resp: got ack=%b err=%b want 1/0", ack, err); else pass_cnt++;
        req = 1'b0; we = 1'b0;
        do_acc(1'b1, 8'h84, 32'hFFFF_FFFF, 4'h0, rd, a, e);
        do_acc(1'b0, 8'h84, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h1) $display("FAIL race_sticky: got %h want 1", rd); else pass_cnt++;
        do_acc(1'b0, 8'h84, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h0) $display("FAIL race_sticky_clr: got %h want 0", rd); else pass_cnt++;
    endtask

    task automatic test_midreset();
        logic [31:0] rd; logic a, e;
        @(negedge clk); buttons = '0; buttons[1] = 1'b1;
        repeat (4) @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'hFFFF_FFF4;
        #2 rst_n = 1'b0;
        @(negedge clk);
        tot_cnt++; if (ack !== 1'b0 || err !== 1'b0 || rdata !== '0) $display("FAIL midrst_resp: got ack=%b err=%b rd=%h want 0/0/0", ack, err, rdata); else pass_cnt++;
        tot_cnt++; if (led_out !== '0 || seg_out !== '0) $display("FAIL midrst_outs: got led=%h seg=%h want 0/0", led_out, seg_out); else pass_cnt++;
        repeat (3) @(negedge clk);
        tot_cnt++; if (ack !== 1'b0) $display("FAIL midrst_held_ack: got %b want 0", ack); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        tot_cnt++; if (ack !== 1'b1 || rdata !== 32'd0) $display("FAIL cyc_first: got ack=%b rd=%h want 1/0", ack, rdata); else pass_cnt++;
        @(negedge clk);
        tot_cnt++; if (ack !== 1'b1 || rdata !== 32'd1) $display("FAIL cyc_second: got ack=%b rd=%h want 1/1", ack, rdata); else pass_cnt++;
        req = 1'b0;
        do_acc(1'b0, 8'h80, '0, 4'h0, rd, a, e);
        tot_cnt++; if (rd !== 32'h0) $display("FAIL midrst_btn_level: got %h want 0", rd); else pass_cnt++;
        buttons = '0;
    endtask

    initial begin
        test_reset();
        test_random(200);
        test_seg_led();
        test_illegal();
        test_buttons();
        test_sticky_race();
        test_midreset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
